// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - default constants and sizing helper shared by the fifo slice
//
// Purpose : holds the default geometry of the fifo and the occupancy
//           counter width function used by fifo and fifo_mem.
package fifo_pkg;

  localparam int FIFO_DATA_W     = 4;
  localparam int FIFO_DEPTH      = 9;
  localparam int FIFO_ALFULL_CNT = 5;

  // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a depth of 1 would otherwise yield a zero-width pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, one write port, one registered read port
//
// Purpose : storage for fifo. The array itself is not reset; only the read
//           data register is, so dout comes out of reset as zero.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           wr_en/wr_addr/wr_data - write port, stored on rising edge
//           rd_en/rd_addr  - read request, rd_data loaded on rising edge
//           rd_data        - registered read data, holds when rd_en is low
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int AW     = ptr_width(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock synchronous fifo with registered status flags
//
// Purpose : first-in first-out buffer of DEPTH entries of DATA_W bits.
//           Optional macro FIFO_ERR_FLAGS_EN adds sticky ovf/udf outputs.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           din, wr_en     - write data / request (dropped when full)
//           rd_en          - read request (ignored when empty)
//           dout           - registered read data, 1-cycle latency
//           buf_empty      - occupancy == 0
//           buf_full       - occupancy == DEPTH
//           alfull         - occupancy >= ALFULL_CNT
//           ovf, udf       - (FIFO_ERR_FLAGS_EN only) sticky dropped-write /
//                            ignored-read indicators, cleared by reset
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ALFULL_CNT = FIFO_ALFULL_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              alfull
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance uses the registered flags, i.e. the pre-edge occupancy, so a
  // write on a full fifo is dropped even if a read frees a slot that cycle.
  assign wr_acc = wr_en && !buf_full;
  assign rd_acc = rd_en && !buf_empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are computed from the next occupancy so they track the counter on
  // the same edge instead of lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      buf_empty <= 1'b1;
      buf_full  <= 1'b0;
      alfull    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      buf_empty <= (count_nxt == '0);
      buf_full  <= (count_nxt == CW'(DEPTH));
      alfull    <= (count_nxt >= CW'(ALFULL_CNT));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && buf_full) begin
        ovf <= 1'b1;
      end
      if (rd_en && buf_empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking scoreboard bench for fifo (DATA_W=4, DEPTH=9, ALFULL_CNT=5)
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] dout;
  logic       buf_empty;
  logic       buf_full;
  logic       alfull;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf;
  logic       udf;
`endif

  always #5 clk = ~clk;

  fifo #(
    .DATA_W     (4),
    .DEPTH      (9),
    .ALFULL_CNT (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .buf_empty (buf_empty),
    .buf_full  (buf_full),
    .alfull    (alfull)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .ovf       (ovf),
    .udf       (udf)
`endif
  );

  // Scoreboard and reference state
  logic [3:0] sb[$];
  int         m_cnt;
  logic [3:0] exp_dout;
  logic       m_ovf;
  logic       m_udf;
  int         n_checks;
  int         n_fail;

  // One clock of stimulus; the scoreboard is updated from the pre-edge model
  // occupancy, mirroring the accept rules of a DEPTH=9 fifo.
  task automatic step(input logic w, input logic [3:0] d, input logic r);
    bit wa;
    bit ra;
    @(negedge clk);
    wr_en = w;
    din   = d;
    rd_en = r;
    wa = w && (m_cnt < 9);
    ra = r && (m_cnt > 0);
    if (w && !wa) m_ovf = 1'b1;
    if (r && !ra) m_udf = 1'b1;
    @(posedge clk);
    #1;
    if (ra) exp_dout = sb.pop_front();
    if (wa) sb.push_back(d);
    m_cnt = sb.size();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_cnt    = 0;
    exp_dout = 4'h0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    n_checks++;
    if ({buf_empty, buf_full, alfull} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got e/f/af=%b required 100", {buf_empty, buf_full, alfull});
    end
    n_checks++;
    if (dout !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_dout: got %h required 0", dout);
    end
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if ({ovf, udf} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_err: got ovf/udf=%b required 00", {ovf, udf});
    end
`endif
    release_reset();
  endtask

  task automatic test_alfull();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i + 3), 1'b0);
      n_checks++;
      if (alfull !== (i == 4)) begin
        n_fail++;
        $display("FAIL alfull_write%0d: got %b required %b", i + 1, alfull, (i == 4));
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 1'b1);
      n_checks++;
      if (dout !== 4'(i + 3)) begin
        n_fail++;
        $display("FAIL alfull_drain%0d: got %h required %h", i, dout, 4'(i + 3));
      end
    end
    n_checks++;
    if ({buf_empty, buf_full, alfull} !== 3'b100) begin
      n_fail++;
      $display("FAIL alfull_end_flags: got %b required 100", {buf_empty, buf_full, alfull});
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 4'(i), 1'b0);
      n_checks++;
      if (buf_full !== (i == 8)) begin
        n_fail++;
        $display("FAIL full_write%0d: got buf_full=%b required %b", i, buf_full, (i == 8));
      end
    end
    step(1'b1, 4'hF, 1'b0);
    n_checks++;
    if ({buf_empty, buf_full, alfull} !== 3'b011) begin
      n_fail++;
      $display("FAIL full_drop_flags: got %b required 011", {buf_empty, buf_full, alfull});
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'h0, 1'b1);
      n_checks++;
      if (dout !== 4'(i) || dout !== exp_dout) begin
        n_fail++;
        $display("FAIL full_read%0d: got %h required %h", i, dout, 4'(i));
      end
      n_checks++;
      if ({buf_empty, buf_full, alfull} !== {m_cnt == 0, m_cnt == 9, m_cnt >= 5}) begin
        n_fail++;
        $display("FAIL full_read_flags%0d: got %b required %b", i, {buf_empty, buf_full, alfull},
                 {m_cnt == 0, m_cnt == 9, m_cnt >= 5});
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ord [9];
    ord = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD};
    for (int i = 0; i < 9; i++) step(1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 1'b1);
      n_checks++;
      if (dout !== 4'(i)) begin
        n_fail++;
        $display("FAIL wrap_pre%0d: got %h required %h", i, dout, 4'(i));
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'(10 + i), 1'b0);
    n_checks++;
    if (buf_full !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_refull: got buf_full=%b required 1", buf_full);
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'h0, 1'b1);
      n_checks++;
      if (dout !== ord[i] || dout !== exp_dout) begin
        n_fail++;
        $display("FAIL wrap_drain%0d: got %h required %h", i, dout, ord[i]);
      end
    end
    n_checks++;
    if (buf_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_empty: got buf_empty=%b required 1", buf_empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 1), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i + 4), 1'b1);
      n_checks++;
      if (dout !== exp_dout || dout !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_dout%0d: got %h required %h", i, dout, 4'(i + 1));
      end
      n_checks++;
      if ({buf_empty, buf_full, alfull} !== 3'b000 || m_cnt != 3) begin
        n_fail++;
        $display("FAIL b2b_flags%0d: got %b required 000", i, {buf_empty, buf_full, alfull});
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 1'b1);
      n_checks++;
      if (dout !== 4'(i + 11)) begin
        n_fail++;
        $display("FAIL b2b_drain%0d: got %h required %h", i, dout, 4'(i + 11));
      end
    end
  endtask

  task automatic test_empty_read();
    logic [3:0] held;
    held = exp_dout;
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    n_checks++;
    if (dout !== held) begin
      n_fail++;
      $display("FAIL empty_read_dout: got %h required %h", dout, held);
    end
    n_checks++;
    if (buf_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read_flag: got buf_empty=%b required 1", buf_empty);
    end
`ifdef FIFO_ERR_FLAGS_EN
    for (int i = 0; i < 9; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'hE, 1'b1);
    n_checks++;
    if (dout !== 4'h0) begin
      n_fail++;
      $display("FAIL full_rw_dout: got %h required 0", dout);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0);
    n_checks++;
    if ({ovf, udf} !== {m_ovf, m_udf} || {ovf, udf} !== 2'b11) begin
      n_fail++;
      $display("FAIL err_sticky: got ovf/udf=%b required 11", {ovf, udf});
    end
    assert_reset();
    release_reset();
    n_checks++;
    if ({ovf, udf} !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clear: got ovf/udf=%b required 00", {ovf, udf});
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i + 5), 1'b0);
    assert_reset();
    n_checks++;
    if ({buf_empty, buf_full, alfull} !== 3'b100 || dout !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset_async: got flags=%b dout=%h required 100/0",
               {buf_empty, buf_full, alfull}, dout);
    end
    release_reset();
    step(1'b1, 4'h9, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    n_checks++;
    if (dout !== 4'h9) begin
      n_fail++;
      $display("FAIL midreset_first_read: got %h required 9", dout);
    end
    n_checks++;
    if (buf_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_empty: got buf_empty=%b required 1", buf_empty);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    din      = 4'h0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    m_cnt    = 0;
    exp_dout = 4'h0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    test_reset();
    test_alfull();
    test_full();
    test_wrap();
    test_back_to_back();
    test_empty_read();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
